ice_pmu_i2c_master: RTL and testbench



---
 rtl/ice_pmu_i2c_master.sv | 128 ++++++++++++
 tb/tb_ice_pmu_i2c_master.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ice_pmu_i2c_master.sv
// Byte-level I2C master for single-register PMU reads and writes.
// A bus bit is four CLK_DIV-cycle quarters. Releasing SCL waits for scl_in high, which honours clock stretching.
module ice_pmu_i2c_master #(
  parameter logic [6:0]  DEV_ADDR = 7'h34,
  parameter logic [15:0] CLK_DIV  = 16'd50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  output logic [7:0] resp_rdata,
  output logic       resp_nak,
  output logic       busy,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe
);
  typedef enum logic [3:0] {IDLE, START, TXBYTE, TXACK, RSTART, RXBYTE, MACK, STOP, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  qtr_q, qtr_d, byte_q, byte_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d, reg_q, reg_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic        wr_q, wr_d, nak_q, nak_d, ready_q, ready_d, busy_q, busy_d;
  logic        rv_q, rv_d, rnak_q, rnak_d, scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
  logic        q_end, lst, sample, q0_first;

  always_comb begin
    q_end    = (cnt_q == CLK_DIV - 16'd1);
    lst      = q_end && (qtr_q == 2'd3);
    sample   = (qtr_q == 2'd3) && (cnt_q == 16'd0);
    q0_first = (qtr_q == 2'd0) && (cnt_q == 16'd0);
    state_d = state_q; qtr_d = qtr_q; cnt_d = cnt_q; bit_d = bit_q; byte_d = byte_q;
    sh_d = sh_q; reg_d = reg_q; wdata_d = wdata_q; wr_d = wr_q; nak_d = nak_q;
    ready_d = ready_q; busy_d = busy_q; rv_d = 1'b0; rdata_d = rdata_q; rnak_d = rnak_q;

    if (state_q != IDLE && state_q != DONE) begin
      if (qtr_q == 2'd2 && cnt_q == 16'd0 && !scl_in) cnt_d = cnt_q;
      else if (q_end) begin cnt_d = 16'd0; qtr_d = qtr_q + 2'd1; end
      else cnt_d = cnt_q + 16'd1;
    end

    case (state_q)
      IDLE: if (req_valid && ready_q) begin
        state_d = START; qtr_d = 2'd3; cnt_d = 16'd0; bit_d = 3'd7; byte_d = 2'd0;
        sh_d = {DEV_ADDR, 1'b0}; reg_d = req_reg; wdata_d = req_wdata; wr_d = req_write;
        nak_d = 1'b0; ready_d = 1'b0; busy_d = 1'b1; rdata_d = 8'h00; rnak_d = 1'b0;
      end
      START: if (lst) state_d = TXBYTE;
      TXBYTE: if (lst) begin
        if (bit_q == 3'd0) state_d = TXACK;
        else begin bit_d = bit_q - 3'd1; sh_d = {sh_q[6:0], 1'b0}; end
      end
      TXACK: begin
        if (sample) nak_d = sda_in;
        if (lst) begin
          bit_d = 3'd7;
          if (nak_q) state_d = STOP;
          else if (byte_q == 2'd0) begin sh_d = reg_q; byte_d = 2'd1; state_d = TXBYTE; end
          else if (byte_q == 2'd1) begin
            if (wr_q) begin sh_d = wdata_q; byte_d = 2'd2; state_d = TXBYTE; end
            else state_d = RSTART;
          end
          else state_d = wr_q ? STOP : RXBYTE;
        end
      end
      RSTART: if (lst) begin sh_d = {DEV_ADDR, 1'b1}; byte_d = 2'd2; bit_d = 3'd7; state_d = TXBYTE; end
      RXBYTE: begin
        if (sample) sh_d = {sh_q[6:0], sda_in};
        if (lst) begin
          if (bit_q == 3'd0) state_d = MACK;
          else bit_d = bit_q - 3'd1;
        end
      end
      MACK: if (lst) state_d = STOP;
      STOP: if (lst) begin
        state_d = DONE; rv_d = 1'b1; rnak_d = nak_q;
        rdata_d = (nak_q || wr_q) ? 8'h00 : sh_q;
      end
      DONE: begin state_d = IDLE; ready_d = 1'b1; busy_d = 1'b0; end
      default: state_d = IDLE;
    endcase

    // SDA moves one cycle into Q0 so it never changes on the same cycle as SCL
    scl_oe_d = 1'b0; sda_oe_d = 1'b0;
    case (state_q)
      START: sda_oe_d = 1'b1;
      TXBYTE, TXACK, RXBYTE, MACK: begin
        scl_oe_d = ~qtr_q[1];
        sda_oe_d = q0_first ? sda_oe_q : ((state_q == TXBYTE) && !sh_q[7]);
      end
      RSTART: begin scl_oe_d = ~qtr_q[1]; sda_oe_d = (qtr_q == 2'd3); end
      STOP: begin
        scl_oe_d = ~qtr_q[1];
        sda_oe_d = q0_first ? sda_oe_q : (qtr_q != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE; qtr_q <= 2'd0; cnt_q <= 16'd0; bit_q <= 3'd0; byte_q <= 2'd0;
      sh_q <= 8'h00; reg_q <= 8'h00; wdata_q <= 8'h00; wr_q <= 1'b0; nak_q <= 1'b0;
      ready_q <= 1'b1; busy_q <= 1'b0; rv_q <= 1'b0; rdata_q <= 8'h00; rnak_q <= 1'b0;
      scl_oe_q <= 1'b0; sda_oe_q <= 1'b0;
    end else begin
      state_q <= state_d; qtr_q <= qtr_d; cnt_q <= cnt_d; bit_q <= bit_d; byte_q <= byte_d;
      sh_q <= sh_d; reg_q <= reg_d; wdata_q <= wdata_d; wr_q <= wr_d; nak_q <= nak_d;
      ready_q <= ready_d; busy_q <= busy_d; rv_q <= rv_d; rdata_q <= rdata_d; rnak_q <= rnak_d;
      scl_oe_q <= scl_oe_d; sda_oe_q <= sda_oe_d;
    end
  end

  assign req_ready  = ready_q;
  assign busy       = busy_q;
  assign resp_valid = rv_q;
  assign resp_rdata = rdata_q;
  assign resp_nak   = rnak_q;
  assign scl_oe     = scl_oe_q;
  assign sda_oe     = sda_oe_q;
endmodule

// File: tb/tb_ice_pmu_i2c_master.sv
// Directed bench for ice_pmu_i2c_master with a behavioural open-drain PMU slave stub.
module tb_ice_pmu_i2c_master;
  localparam logic [15:0] DIV = 16'd8;
  localparam int RD_LIM = 170 * DIV;
  localparam int WR_LIM = 125 * DIV;

  logic clk = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_write = 1'b0;
  logic [7:0] req_reg = 8'h00, req_wdata = 8'h00;
  logic req_ready, resp_valid, resp_nak, busy, scl_oe, sda_oe;
  logic [7:0] resp_rdata;
  logic stub_scl_hold = 1'b0, stub_sda_low = 1'b0;
  logic scl, sda;
  assign scl = ~scl_oe & ~stub_scl_hold;
  assign sda = ~sda_oe & ~stub_sda_low;

  always #5 clk = ~clk;

  ice_pmu_i2c_master #(.DEV_ADDR(7'h34), .CLK_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_reg(req_reg), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_nak(resp_nak), .busy(busy),
    .scl_in(scl), .sda_in(sda), .scl_oe(scl_oe), .sda_oe(sda_oe));

  // Slave stub: phase 0 = receive bits, 1 = ack slot, 2 = send bits, 3 = master ack slot, 4 = wait
  bit present = 1'b1, stub_clr = 1'b0, clr_seen = 1'b0, ack = 1'b0, rd = 1'b0, in_txn = 1'b0;
  logic [7:0] rdata_ret = 8'h7f, sh = 8'h00, txsh = 8'h00;
  logic prev_scl = 1'b1, prev_sda = 1'b1, mack_bit = 1'b0;
  int phase = 4, bits = 0, byte_idx = 0, starts = 0, rstarts = 0, stops = 0, acks = 0, naks = 0, falls = 0;
  logic [7:0] log_q[$];

  always @(scl, sda, stub_clr) begin
    if (stub_clr != clr_seen) begin
      clr_seen = stub_clr; in_txn = 0; phase = 4; bits = 0; byte_idx = 0; starts = 0; rstarts = 0;
      stops = 0; acks = 0; naks = 0; falls = 0; mack_bit = 1'b0; stub_sda_low = 1'b0; log_q.delete();
    end else if (prev_scl === 1'b1 && scl === 1'b1 && prev_sda === 1'b1 && sda === 1'b0) begin
      if (in_txn) rstarts++; else begin starts++; falls = 0; end
      in_txn = 1; phase = 0; bits = 0; byte_idx = 0;
    end else if (prev_scl === 1'b1 && scl === 1'b1 && prev_sda === 1'b0 && sda === 1'b1) begin
      stops++; in_txn = 0; phase = 4;
    end else if (in_txn && prev_scl === 1'b0 && scl === 1'b1) begin
      if (phase == 0) begin
        sh = {sh[6:0], sda}; bits++;
        if (bits == 8) begin
          log_q.push_back(sh);
          if (byte_idx == 0) begin ack = present && (sh[7:1] == 7'h34); rd = sh[0]; end
          else ack = 1'b1;
        end
      end else if (phase == 1) begin
        if (sda === 1'b0) acks++; else naks++;
      end else if (phase == 2) bits++;
      else if (phase == 3) mack_bit = sda;
    end else if (in_txn && prev_scl === 1'b1 && scl === 1'b0) begin
      falls++;
      if (phase == 0 && bits == 8) begin phase = 1; stub_sda_low = ack; end
      else if (phase == 1) begin
        stub_sda_low = 1'b0; bits = 0;
        if (ack && rd && byte_idx == 0) begin phase = 2; txsh = rdata_ret; stub_sda_low = ~txsh[7]; end
        else phase = 0;
        byte_idx++;
      end else if (phase == 2) begin
        if (bits == 8) begin stub_sda_low = 1'b0; phase = 3; end
        else stub_sda_low = ~txsh[7-bits];
      end else if (phase == 3) phase = 4;
    end
    prev_scl = scl; prev_sda = sda;
  end

  int checks = 0, errors = 0, base_lat = 0;

  function automatic logic [31:0] log_word();
    logic [31:0] w = 32'h0;
    foreach (log_q[i]) w = {w[23:0], log_q[i]};
    return w;
  endfunction

  task automatic run_txn(input bit wr, input logic [7:0] r, input logic [7:0] d, input int limit,
                         output int lat, output int rv_cnt, output logic [7:0] rdata, output logic nak,
                         output logic rdy_after, output logic [7:0] rdata_acc, output bit timed_out);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_reg = r; req_wdata = d;
    @(posedge clk); #1;
    rdata_acc = resp_rdata;
    req_valid = 1'b0; req_write = ~wr; req_reg = 8'hEE; req_wdata = 8'h11;
    lat = 0; rv_cnt = 0; timed_out = 1'b1; rdata = 8'hxx; nak = 1'bx; rdy_after = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1; lat++;
      if (resp_valid) begin rv_cnt++; rdata = resp_rdata; nak = resp_nak; timed_out = 1'b0; break; end
    end
    if (!timed_out) begin
      @(posedge clk); #1;
      rdy_after = req_ready;
      if (resp_valid) rv_cnt++;
    end
  endtask

  task automatic clear_stub();
    stub_clr = ~stub_clr; #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_rv: got %b exp 0", resp_valid); end
    checks++; if (resp_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h exp 00", resp_rdata); end
    checks++; if (resp_nak !== 1'b0) begin errors++; $display("FAIL reset_nak: got %b exp 0", resp_nak); end
    checks++; if ({scl_oe, sda_oe} !== 2'b00) begin errors++; $display("FAIL reset_oe: got %b exp 00", {scl_oe, sda_oe}); end
    reset = 1'b0; clear_stub();
    repeat (4) @(posedge clk); #1;
    checks++; if ({scl_oe, sda_oe, busy} !== 3'b000) begin errors++; $display("FAIL idle_after_reset: got %b exp 000", {scl_oe, sda_oe, busy}); end
  endtask

  task automatic test_read_7f();
    int lat, rv; logic [7:0] rdat, racc; logic nk, rdy; bit to;
    clear_stub(); present = 1'b1; rdata_ret = 8'h7f;
    run_txn(1'b0, 8'h10, 8'h00, RD_LIM, lat, rv, rdat, nk, rdy, racc, to);
    base_lat = lat;
    checks++; if (to) begin errors++; $display("FAIL rd_timeout: got timeout after %0d exp resp_valid", lat); end
    checks++; if (lat < 140 * DIV) begin errors++; $display("FAIL rd_latency_low: got %0d exp >= %0d", lat, 140 * DIV); end
    checks++; if (rv !== 1) begin errors++; $display("FAIL rd_rv_once: got %0d exp 1", rv); end
    checks++; if (rdat !== 8'h7f) begin errors++; $display("FAIL rd_data: got %h exp 7f", rdat); end
    checks++; if (nk !== 1'b0) begin errors++; $display("FAIL rd_nak: got %b exp 0", nk); end
    checks++; if (log_q.size() !== 3 || log_word() !== 32'h00681069) begin errors++; $display("FAIL rd_bus_bytes: got %0d bytes %h exp 3 bytes 00681069", log_q.size(), log_word()); end
    checks++; if (mack_bit !== 1'b1) begin errors++; $display("FAIL rd_master_nack: got %b exp 1", mack_bit); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rd_ready_after: got %b exp 1", rdy); end
  endtask

  task automatic test_read_00();
    int lat, rv; logic [7:0] rdat, racc; logic nk, rdy; bit to;
    clear_stub(); rdata_ret = 8'h00;
    run_txn(1'b0, 8'h10, 8'h00, RD_LIM, lat, rv, rdat, nk, rdy, racc, to);
    checks++; if (racc !== 8'h00) begin errors++; $display("FAIL rdata_clear_on_accept: got %h exp 00", racc); end
    checks++; if (to || rdat !== 8'h00 || nk !== 1'b0) begin errors++; $display("FAIL rd0_result: got to=%b data=%h nak=%b exp 0 00 0", to, rdat, nk); end
    checks++; if ({starts, rstarts, stops} !== {32'd1, 32'd1, 32'd1}) begin errors++; $display("FAIL rd0_conditions: got S=%0d Sr=%0d P=%0d exp 1 1 1", starts, rstarts, stops); end
  endtask

  task automatic test_write();
    int lat, rv; logic [7:0] rdat, racc; logic nk, rdy; bit to;
    clear_stub(); present = 1'b1;
    run_txn(1'b1, 8'h05, 8'hA5, WR_LIM, lat, rv, rdat, nk, rdy, racc, to);
    checks++; if (to) begin errors++; $display("FAIL wr_timeout: got timeout after %0d exp resp_valid", lat); end
    checks++; if (lat < 100 * DIV) begin errors++; $display("FAIL wr_latency_low: got %0d exp >= %0d", lat, 100 * DIV); end
    checks++; if (rdat !== 8'h00 || nk !== 1'b0 || rv !== 1) begin errors++; $display("FAIL wr_result: got data=%h nak=%b rv=%0d exp 00 0 1", rdat, nk, rv); end
    checks++; if (log_q.size() !== 3 || log_word() !== 32'h006805A5) begin errors++; $display("FAIL wr_bus_bytes: got %0d bytes %h exp 3 bytes 006805a5", log_q.size(), log_word()); end
    checks++; if (acks !== 3 || naks !== 0 || rstarts !== 0 || stops !== 1) begin errors++; $display("FAIL wr_bus_events: got ack=%0d nak=%0d Sr=%0d P=%0d exp 3 0 0 1", acks, naks, rstarts, stops); end
  endtask

  task automatic test_nak();
    int lat, rv; logic [7:0] rdat, racc; logic nk, rdy; bit to;
    clear_stub(); present = 1'b0;
    run_txn(1'b0, 8'h10, 8'h00, RD_LIM, lat, rv, rdat, nk, rdy, racc, to);
    checks++; if (to || nk !== 1'b1) begin errors++; $display("FAIL nak_flag: got to=%b nak=%b exp 0 1", to, nk); end
    checks++; if (rdat !== 8'h00) begin errors++; $display("FAIL nak_rdata: got %h exp 00", rdat); end
    checks++; if (log_q.size() !== 1 || log_word() !== 32'h00000068 || rstarts !== 0 || stops !== 1) begin errors++; $display("FAIL nak_stop_after_addr: got %0d bytes %h Sr=%0d P=%0d exp 1 68 0 1", log_q.size(), log_word(), rstarts, stops); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL nak_ready_after: got %b exp 1", rdy); end
    present = 1'b1;
  endtask

  task automatic test_stretch();
    int lat, rv; logic [7:0] rdat, racc; logic nk, rdy; bit to;
    bit held = 1'b0;
    clear_stub(); present = 1'b1; rdata_ret = 8'h7f;
    fork
      run_txn(1'b0, 8'h10, 8'h00, RD_LIM + 400, lat, rv, rdat, nk, rdy, racc, to);
      begin
        for (int i = 0; i < 2000 && falls < 4; i++) begin @(posedge clk); #1; end
        if (falls >= 4) begin
          held = 1'b1; stub_scl_hold = 1'b1;
          repeat (300) @(posedge clk);
          #1 stub_scl_hold = 1'b0;
        end
      end
    join
    checks++; if (!held) begin errors++; $display("FAIL stretch_applied: got %b exp 1", held); end
    checks++; if (to || rdat !== 8'h7f || nk !== 1'b0) begin errors++; $display("FAIL stretch_data: got to=%b data=%h nak=%b exp 0 7f 0", to, rdat, nk); end
    checks++; if (log_word() !== 32'h00681069) begin errors++; $display("FAIL stretch_bus_bytes: got %h exp 00681069", log_word()); end
    checks++; if (lat - base_lat < 250 || lat - base_lat > 310) begin errors++; $display("FAIL stretch_extra_latency: got %0d exp 250..310", lat - base_lat); end
  endtask

  task automatic test_reset_mid();
    int lat, rv, rv_seen; logic [7:0] rdat, racc; logic nk, rdy; bit to, found;
    clear_stub(); rdata_ret = 8'h7f;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_reg = 8'h10;
    @(posedge clk); #1 req_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < RD_LIM; i++) begin
      @(posedge clk); #1;
      if (phase == 2 && bits == 4) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL rst_reach_rxbit4: got %b exp 1", found); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({scl_oe, sda_oe} !== 2'b00) begin errors++; $display("FAIL rst_async_release: got %b exp 00", {scl_oe, sda_oe}); end
    clear_stub();
    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    rv_seen = 0;
    repeat (50) begin @(posedge clk); #1; if (resp_valid) rv_seen++; end
    checks++; if (rv_seen !== 0 || busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_no_resp: got rv=%0d busy=%b ready=%b exp 0 0 1", rv_seen, busy, req_ready); end
    clear_stub();
    run_txn(1'b0, 8'h10, 8'h00, RD_LIM, lat, rv, rdat, nk, rdy, racc, to);
    checks++; if (to || rdat !== 8'h7f || nk !== 1'b0) begin errors++; $display("FAIL rst_then_read: got to=%b data=%h nak=%b exp 0 7f 0", to, rdat, nk); end
  endtask

  task automatic test_back_to_back();
    int rv = 0, starts_first = -1;
    clear_stub(); rdata_ret = 8'h5a;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_reg = 8'h10;
    for (int i = 0; i < 3 * RD_LIM; i++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        rv++;
        if (rv == 1) starts_first = starts;
        if (rv == 2) break;
      end else if (rv == 1 && busy) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    checks++; if (starts_first !== 1) begin errors++; $display("FAIL hold_one_start_before_resp: got %0d exp 1", starts_first); end
    checks++; if (rv !== 2 || starts !== 2 || stops !== 2) begin errors++; $display("FAIL hold_two_txns: got rv=%0d S=%0d P=%0d exp 2 2 2", rv, starts, stops); end
    checks++; if (resp_rdata !== 8'h5a) begin errors++; $display("FAIL hold_rdata: got %h exp 5a", resp_rdata); end
  endtask

  initial begin
    test_reset();
    test_read_7f();
    test_read_00();
    test_write();
    test_nak();
    test_stretch();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
